game_state_ctrl: RTL and testbench

- Game-level sequencer for the stickman runner; sits directly upstream of the colour mapper and drives its one-hot status {waiting, playing, win, lose}.
- Consumes keyboard keycodes, coin-hit pulses and the fall condition from the stickman/ground logic, plus the VGA vertical-sync frame clock.
- Produces the status, the coin score, the seconds remaining, and a one-cycle round-restart pulse for the stickman, ground and coin blocks.

---
 rtl/stickman_pkg.sv | 21 ++
 rtl/game_state_ctrl_if.sv | 22 ++
 rtl/game_state_ctrl_frame_sec_timer.sv | 49 ++++
 rtl/game_state_ctrl.sv | 138 +++++++++++++
 tb/tb_game_state_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/stickman_pkg.sv
// Shared types and constants for the stickman runner game logic.
// The STATUS_* encodings are also consumed by the colour mapper.
package stickman_pkg;

  typedef enum logic [2:0] {
    WAITING = 3'd0,
    PLAYING = 3'd1,
    WIN     = 3'd2,
    LOSE    = 3'd3,
    PAUSED  = 3'd4
  } game_state_t;

  localparam logic [3:0] STATUS_WAITING = 4'b1000;
  localparam logic [3:0] STATUS_PLAYING = 4'b0100;
  localparam logic [3:0] STATUS_WIN     = 4'b0010;
  localparam logic [3:0] STATUS_LOSE    = 4'b0001;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_P     = 8'h13;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Game-level signals between the input blocks and the sequencer.
// master drives the game inputs; slave is the sequencer side.
interface game_state_ctrl_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       coin_hit;
  logic       fell;
  logic [3:0] status;
  logic [7:0] score;
  logic [7:0] time_left;
  logic       round_start;

  modport master (
    output frame_clk, keycode, coin_hit, fell,
    input  status, score, time_left, round_start
  );

  modport slave (
    input  frame_clk, keycode, coin_hit, fell,
    output status, score, time_left, round_start
  );
endinterface

// File: rtl/game_state_ctrl_frame_sec_timer.sv
// Frame-to-second timer: detects frame_clk rising edges, divides them
// into seconds, and counts the round time down to zero.
module frame_sec_timer #(
  parameter logic [7:0] TIME_LIMIT     = 8'd60,
  parameter logic [6:0] FRAMES_PER_SEC = 7'd60
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       run,
  input  logic       load,
  output logic       sec_evt,
  output logic [7:0] time_left
);

  logic       frame_clk_q;
  logic [6:0] frame_cnt;
  logic       frame_evt;
  logic       time_zero;

  assign frame_evt = frame_clk && !frame_clk_q;
  assign sec_evt   = run && frame_evt && (frame_cnt == FRAMES_PER_SEC - 7'd1);
  assign time_zero = (time_left == 8'd0);

  // Frame edge history and frame counter; counter holds whenever not running.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_q <= 1'b0;
      frame_cnt   <= 7'd0;
    end else begin
      frame_clk_q <= frame_clk;
      if (load)
        frame_cnt <= 7'd0;
      else if (run && frame_evt)
        frame_cnt <= sec_evt ? 7'd0 : frame_cnt + 7'd1;
    end
  end

  // Seconds-remaining down-counter, saturating at zero.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      time_left <= TIME_LIMIT;
    else if (load)
      time_left <= TIME_LIMIT;
    else if (sec_evt && !time_zero)
      time_left <= time_left - 8'd1;
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game-level sequencer for the stickman runner.
// Optional build macro GAME_PAUSE_EN adds a PAUSED state toggled by PAUSE_KEY.
//
// state   | meaning
// WAITING | idle, waiting for START_KEY to begin a round
// PLAYING | round running: coins score, seconds count down
// WIN     | WIN_COINS collected; score/time frozen until START_KEY
// LOSE    | fell or ran out of time; frozen until START_KEY
// PAUSED  | (GAME_PAUSE_EN) round frozen; PAUSE_KEY resumes, START_KEY quits
module game_state_ctrl
  import stickman_pkg::*;
#(
  parameter logic [7:0] START_KEY      = KEY_ENTER,
  parameter logic [7:0] WIN_COINS      = 8'd10,
  parameter logic [7:0] TIME_LIMIT     = 8'd60,
  parameter logic [6:0] FRAMES_PER_SEC = 7'd60
`ifdef GAME_PAUSE_EN
  ,
  parameter logic [7:0] PAUSE_KEY      = KEY_P
`endif
) (
  input logic               Clk,
  input logic               Reset_n,
  game_state_ctrl_if.slave  bus
);

  game_state_t state;
  logic [7:0]  keycode_q;
  logic [3:0]  status_q;
  logic [7:0]  score_q;
  logic        round_start_q;
  logic [7:0]  time_left;
  logic        sec_evt;
  logic        start_evt;
  logic        run;
  logic        load;

  assign start_evt = (bus.keycode == START_KEY) && (keycode_q != START_KEY);
`ifdef GAME_PAUSE_EN
  logic pause_evt;
  assign pause_evt = (bus.keycode == PAUSE_KEY) && (keycode_q != PAUSE_KEY);
`endif

  assign run  = (state == PLAYING);
  assign load = (state == WAITING) && start_evt;

  frame_sec_timer #(
    .TIME_LIMIT     (TIME_LIMIT),
    .FRAMES_PER_SEC (FRAMES_PER_SEC)
  ) u_timer (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (bus.frame_clk),
    .run       (run),
    .load      (load),
    .sec_evt   (sec_evt),
    .time_left (time_left)
  );

  // Keycode history so a held key produces a single event.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      keycode_q <= 8'h00;
    else
      keycode_q <= bus.keycode;
  end

  // Game FSM with registered status, score and round_start.
  // Score updates independently of the transition chosen, so a coin that
  // arrives with a fall still counts.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= WAITING;
      status_q      <= STATUS_WAITING;
      score_q       <= 8'd0;
      round_start_q <= 1'b0;
    end else begin
      round_start_q <= 1'b0;
      case (state)
        WAITING: begin
          if (start_evt) begin
            state         <= PLAYING;
            status_q      <= STATUS_PLAYING;
            score_q       <= 8'd0;
            round_start_q <= 1'b1;
          end
        end
        PLAYING: begin
          if (bus.coin_hit && score_q != 8'hFF)
            score_q <= score_q + 8'd1;
          if (bus.fell) begin
            state    <= LOSE;
            status_q <= STATUS_LOSE;
          end else if (bus.coin_hit && score_q == WIN_COINS - 8'd1) begin
            state    <= WIN;
            status_q <= STATUS_WIN;
          end else if (sec_evt && time_left == 8'd1) begin
            state    <= LOSE;
            status_q <= STATUS_LOSE;
          end
`ifdef GAME_PAUSE_EN
          else if (pause_evt) begin
            state    <= PAUSED;
            status_q <= STATUS_PLAYING;
          end
`endif
        end
        WIN, LOSE: begin
          if (start_evt) begin
            state    <= WAITING;
            status_q <= STATUS_WAITING;
          end
        end
`ifdef GAME_PAUSE_EN
        PAUSED: begin
          if (start_evt) begin
            state    <= WAITING;
            status_q <= STATUS_WAITING;
          end else if (pause_evt) begin
            state    <= PLAYING;
            status_q <= STATUS_PLAYING;
          end
        end
`endif
        default: begin
          state    <= WAITING;
          status_q <= STATUS_WAITING;
        end
      endcase
    end
  end

  assign bus.status      = status_q;
  assign bus.score       = score_q;
  assign bus.time_left   = time_left;
  assign bus.round_start = round_start_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed testbench for game_state_ctrl with FRAMES_PER_SEC=2,
// TIME_LIMIT=3, WIN_COINS=3.
module tb_game_state_ctrl;

  logic Clk;
  logic Reset_n;
  int   total;
  int   bad;
  int   pulses;

  game_state_ctrl_if bus ();

  game_state_ctrl #(
    .START_KEY      (8'h28),
    .WIN_COINS      (8'd3),
    .TIME_LIMIT     (8'd3),
    .FRAMES_PER_SEC (7'd2)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [7:0] key);
    bus.keycode = key;
    tick();
    bus.keycode = 8'h00;
    tick();
  endtask

  task automatic coin();
    bus.coin_hit = 1'b1;
    tick();
    bus.coin_hit = 1'b0;
  endtask

  task automatic frame_edge();
    bus.frame_clk = 1'b1;
    tick();
    bus.frame_clk = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.frame_clk = 1'b0;
    bus.keycode   = 8'h00;
    bus.coin_hit  = 1'b0;
    bus.fell      = 1'b0;
    Reset_n = 1'b0;
    #23;
    check("rst_status", bus.status, 4'b1000);
    check("rst_score", bus.score, 8'd0);
    check("rst_time", bus.time_left, 8'd3);
    check("rst_rstart", bus.round_start, 1'b0);
    Reset_n = 1'b1;
    tick();
    check("idle_status", bus.status, 4'b1000);

    // Start key held 10 cycles: one event, one round_start pulse
    bus.keycode = 8'h28;
    tick();
    check("start_status", bus.status, 4'b0100);
    check("start_pulse", bus.round_start, 1'b1);
    check("start_score", bus.score, 8'd0);
    check("start_time", bus.time_left, 8'd3);
    pulses = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.round_start) pulses++;
    end
    check("hold_pulses", pulses, 1);
    check("hold_status", bus.status, 4'b0100);
    bus.keycode = 8'h00;
    tick();

    // Three coins win the round; further coins ignored
    coin();
    check("coin1", bus.score, 8'd1);
    check("coin1_status", bus.status, 4'b0100);
    coin();
    check("coin2", bus.score, 8'd2);
    coin();
    check("coin3", bus.score, 8'd3);
    check("win_status", bus.status, 4'b0010);
    coin();
    tick();
    check("win_frozen", bus.score, 8'd3);
    check("win_time", bus.time_left, 8'd3);

    // WIN -> WAITING -> PLAYING
    press(8'h28);
    check("win_ack", bus.status, 4'b1000);
    check("wait_score_kept", bus.score, 8'd3);
    press(8'h28);
    check("r2_status", bus.status, 4'b0100);
    check("r2_score", bus.score, 8'd0);

    // Timeout: six frame edges
    frame_edge();
    check("f1_time", bus.time_left, 8'd3);
    frame_edge();
    check("f2_time", bus.time_left, 8'd2);
    frame_edge();
    frame_edge();
    check("f4_time", bus.time_left, 8'd1);
    frame_edge();
    check("f5_status", bus.status, 4'b0100);
    frame_edge();
    check("f6_time", bus.time_left, 8'd0);
    check("f6_status", bus.status, 4'b0001);
    frame_edge();
    frame_edge();
    check("lose_time_frozen", bus.time_left, 8'd0);

    // Coin/fell ignored in LOSE
    bus.fell = 1'b1;
    coin();
    bus.fell = 1'b0;
    tick();
    check("lose_ignore_score", bus.score, 8'd0);
    check("lose_ignore_status", bus.status, 4'b0001);

    // LOSE -> WAITING -> PLAYING
    press(8'h28);
    check("lose_ack", bus.status, 4'b1000);
    check("lose_ack_time", bus.time_left, 8'd0);
    press(8'h28);
    check("r3_status", bus.status, 4'b0100);
    check("r3_score", bus.score, 8'd0);
    check("r3_time", bus.time_left, 8'd3);

    // Fell together with the winning coin: LOSE, score still counts
    coin();
    coin();
    check("r3_score2", bus.score, 8'd2);
    bus.fell = 1'b1;
    coin();
    bus.fell = 1'b0;
    check("fellwin_status", bus.status, 4'b0001);
    check("fellwin_score", bus.score, 8'd3);

    // Winning coin together with the final second: WIN, time still decrements
    press(8'h28);
    press(8'h28);
    coin();
    coin();
    for (int i = 0; i < 5; i++) frame_edge();
    check("r4_time", bus.time_left, 8'd1);
    bus.frame_clk = 1'b1;
    bus.coin_hit  = 1'b1;
    tick();
    bus.frame_clk = 1'b0;
    bus.coin_hit  = 1'b0;
    check("wintime_status", bus.status, 4'b0010);
    check("wintime_score", bus.score, 8'd3);
    check("wintime_time", bus.time_left, 8'd0);

    // Mid-round asynchronous reset
    press(8'h28);
    press(8'h28);
    coin();
    frame_edge();
    frame_edge();
    #2;
    Reset_n = 1'b0;
    #1;
    check("mrst_status", bus.status, 4'b1000);
    check("mrst_score", bus.score, 8'd0);
    check("mrst_time", bus.time_left, 8'd3);
    check("mrst_rstart", bus.round_start, 1'b0);
    #3;
    Reset_n = 1'b1;
    tick();
    check("mrst_after", bus.status, 4'b1000);
    check("mrst_rstart2", bus.round_start, 1'b0);

`ifdef GAME_PAUSE_EN
    // Pause freezes frame counter and time; coins ignored while paused
    press(8'h28);
    check("p_start", bus.status, 4'b0100);
    frame_edge();
    press(8'h13);
    check("p_status", bus.status, 4'b0100);
    for (int i = 0; i < 4; i++) frame_edge();
    coin();
    tick();
    check("p_time", bus.time_left, 8'd3);
    check("p_score", bus.score, 8'd0);
    press(8'h13);
    check("p_resume_time", bus.time_left, 8'd3);
    frame_edge();
    check("p_resume_tick", bus.time_left, 8'd2);
    coin();
    check("p_resume_coin", bus.score, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
